// File: rtl/seg_display_mux.sv
// seg_display_mux: scans a 12-bit status word onto a 3-digit multiplexed
// 7-segment display. Each digit slot opens with a blanking gap to avoid ghosting.
// The word is latched once per frame so a digit never tears mid-scan.
// Optional feature macro: SEG_BLINK_EN adds the blink input and a frame-rate blink gate.
module seg_display_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] seg_digits,
`ifdef SEG_BLINK_EN
  input  logic        blink,
`endif
  output logic [6:0]  seg,
  output logic [2:0]  seg_an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  // Reject parameter sets that leave no lit time or no blanking gap.
  if (REFRESH_DIV <= BLANK_CYCLES + 1) begin : g_bad_div
    $error("seg_display_mux: REFRESH_DIV must exceed BLANK_CYCLES+1");
  end
  if (BLANK_CYCLES < 2) begin : g_bad_blank
    $error("seg_display_mux: BLANK_CYCLES must be at least 2");
  end

  logic [CW-1:0] r_slot_cnt;
  logic [1:0]    r_digit_idx;
  logic [11:0]   r_shadow;
  logic [6:0]    r_seg;
  logic [2:0]    r_seg_an;

  logic [1:0]    w_idx;
  logic          w_slot_wrap;
  logic          w_frame_start;
  logic          w_blank;
  logic          w_dark;
  logic [3:0]    w_nibble;
  logic [6:0]    w_glyph;
  logic [2:0]    w_an_hot;

  // digit_idx of 3 cannot be reached; if it ever appears, it behaves as digit 0
  assign w_idx         = (r_digit_idx == 2'd3) ? 2'd0 : r_digit_idx;
  assign w_slot_wrap   = (r_slot_cnt == SLOT_LAST);
  assign w_frame_start = (r_slot_cnt == '0) && (w_idx == 2'd0);
  assign w_blank       = (r_slot_cnt < BLANK_END);

`ifdef SEG_BLINK_EN
  localparam int PB = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 0;

  if ((1 << PB) != BLINK_FRAMES) begin : g_bad_blink
    $error("seg_display_mux: BLINK_FRAMES must be a power of 2");
  end

  logic [PB:0] r_frame_cnt;
  logic        r_blink_lat;

  // Count completed frames and take the blink request at the frame latch point
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_blink_lat <= 1'b0;
    end else begin
      if (w_slot_wrap && (w_idx == 2'd2)) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_frame_start) begin
        r_blink_lat <= blink;
      end
    end
  end

  assign w_dark = r_blink_lat & r_frame_cnt[PB];
`else
  assign w_dark = 1'b0;
`endif

  // Scan counters and the once-per-frame shadow copy of the status word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= 2'd0;
      r_shadow    <= 12'h000;
    end else begin
      if (w_slot_wrap) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= (w_idx == 2'd2) ? 2'd0 : (w_idx + 2'd1);
      end else begin
        r_slot_cnt  <= r_slot_cnt + CW'(1);
      end
      if (w_frame_start) begin
        r_shadow <= seg_digits;
      end
    end
  end

  // Select the nibble belonging to the digit currently being scanned
  always_comb begin
    w_nibble = r_shadow[3:0];
    case (w_idx)
      2'd1:    w_nibble = r_shadow[7:4];
      2'd2:    w_nibble = r_shadow[11:8];
      default: w_nibble = r_shadow[3:0];
    endcase
  end

  // Hex glyph decode, active-high gfedcba with bit0 = segment a
  always_comb begin
    w_glyph = 7'h00;
    case (w_nibble)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = 7'h00;
    endcase
  end

  // One anode at most: the scanned digit, and only after the blanking gap
  for (genvar gi = 0; gi < 3; gi++) begin : g_an
    assign w_an_hot[gi] = (w_idx == 2'(gi)) && !w_blank && !w_dark;
  end

  // Registered pin drive, polarity applied last
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg    <= {7{ACTIVE_LOW}};
      r_seg_an <= {3{ACTIVE_LOW}};
    end else begin
      r_seg    <= ACTIVE_LOW ? ~w_glyph : w_glyph;
      r_seg_an <= ACTIVE_LOW ? ~w_an_hot : w_an_hot;
    end
  end

  assign seg    = r_seg;
  assign seg_an = r_seg_an;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed bench for seg_display_mux with a per-cycle
// expectation queue. Outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_seg_display_mux;

  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] seg_digits = 12'h000;
`ifdef SEG_BLINK_EN
  logic        blink = 1'b0;
`endif
  logic [6:0]  seg;
  logic [2:0]  seg_an;

  typedef struct {
    logic [2:0] an;
    logic [6:0] seg;
    bit         chk_seg;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  logic [6:0] glyph_tbl [16];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  seg_display_mux #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .ACTIVE_LOW  (1'b1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_digits(seg_digits),
`ifdef SEG_BLINK_EN
    .blink     (blink),
`endif
    .seg       (seg),
    .seg_an    (seg_an)
  );

  task automatic check_out(input logic [2:0] an_exp, input logic [6:0] seg_exp,
                           input bit chk_seg, input string tag);
    total++;
    assert (seg_an === an_exp) else begin
      bad++;
      $error("FAIL %s seg_an got=%b want=%b", tag, seg_an, an_exp);
    end
    if (chk_seg) begin
      total++;
      assert (seg === seg_exp) else begin
        bad++;
        $error("FAIL %s seg got=%h want=%h", tag, seg, seg_exp);
      end
    end
    $display("%s an=%b seg=%h", tag, seg_an, seg);
  endtask

  // One digit slot: blanking cycles first, then the lit digit (or dark if blinked off)
  task automatic push_slot(input int d, input logic [3:0] nib, input bit dark, input string tag);
    exp_t e;
    for (int c = 0; c < RD; c++) begin
      e.tag = $sformatf("%s_d%0d_c%0d", tag, d, c);
      if (c < BC || dark) begin
        e.an      = 3'b111;
        e.seg     = 7'h00;
        e.chk_seg = 1'b0;
      end else begin
        e.an      = ~(3'b001 << d);
        e.seg     = ~glyph_tbl[nib];
        e.chk_seg = 1'b1;
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [11:0] w, input bit dark, input string tag);
    push_slot(0, w[3:0], dark, tag);
    push_slot(1, w[7:4], dark, tag);
    push_slot(2, w[11:8], dark, tag);
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_empty got=0 entries want>0");
      end else begin
        e = sb_q.pop_front();
        check_out(e.an, e.seg, e.chk_seg, e.tag);
      end
    end
  endtask

  initial begin
    glyph_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reset hold: everything inactive
    rst = 1'b1;
    seg_digits = 12'h500;
    repeat (3) begin
      @(negedge clk);
      check_out(3'b111, 7'h7F, 1'b1, "rst_hold");
    end
    rst = 1'b0;

    // Static word, two frames; first frame also covers first-anode latency
    push_frame(12'h500, 1'b0, "static0");
    drain(3 * RD);
    push_frame(12'h500, 1'b0, "static1");
    drain(3 * RD);

    // Frame-atomic update: change arrives during slot 1
    seg_digits = 12'h100;
    push_frame(12'h100, 1'b0, "atomic0");
    drain(RD + RD / 2);
    seg_digits = 12'h501;
    drain(2 * RD - RD / 2);
    push_frame(12'h501, 1'b0, "atomic1");
    drain(3 * RD);

    // Decode sweep through all 16 glyphs on the rightmost digit
    for (int v = 0; v < 16; v++) begin
      seg_digits = {8'h00, 4'(v)};
      push_frame({8'h00, 4'(v)}, 1'b0, $sformatf("sweep%0d", v));
      drain(3 * RD);
    end

    // Reset in the middle of digit 2's lit time
    seg_digits = 12'h0A3;
    push_frame(12'h0A3, 1'b0, "pre_rst");
    drain(2 * RD + BC + 2);
    sb_q.delete();
    rst = 1'b1;
    seg_digits = 12'hC7E;
    @(negedge clk);
    check_out(3'b111, 7'h7F, 1'b1, "mid_rst");
    rst = 1'b0;
    push_frame(12'hC7E, 1'b0, "post_rst");
    drain(3 * RD);

`ifdef SEG_BLINK_EN
    // Blink: frame counter restarts at 0, phase is bit 1 of the frame count
    rst = 1'b1;
    blink = 1'b1;
    seg_digits = 12'h2B9;
    @(negedge clk);
    check_out(3'b111, 7'h7F, 1'b1, "blink_rst");
    rst = 1'b0;
    for (int f = 0; f < 6; f++) begin
      push_frame(12'h2B9, ((f / 2) % 2) == 1, $sformatf("blink_f%0d", f));
      drain(3 * RD);
    end
    blink = 1'b0;
    for (int f = 6; f < 8; f++) begin
      push_frame(12'h2B9, 1'b0, $sformatf("unblink_f%0d", f));
      drain(3 * RD);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
